slot_bank_sequencer: RTL and testbench

- Parametrised successor to the single DMA descriptor slot: holds NUM_SLOTS descriptors (src addr/size, dst addr/size, status, profile) in one bank.
- Adds an internal sequencer that walks the slots in order and issues each ARMED slot to the DMA engine over a valid/ready command port.
- On completion it writes status and a cycle-count profile back into the slot.
- Sits between the host register interface and the DMA command/completion interface of the DFX sequencer.

---
 rtl/slot_pkg.sv | 6 +
 rtl/slot_entry.sv | 76 +++++++
 rtl/slot_bank_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_slot_bank_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// slot_pkg: shared encodings for the descriptor slot bank and its sequencer.
package slot_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_ARMED, ST_BUSY, ST_DONE} status_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_e;
    localparam logic [31:0] SAT = 32'hFFFF_FFFF;
endpackage

// File: rtl/slot_entry.sv
// slot_entry: one descriptor register; host field writes are gated by lock,
// the sequencer status/profile port always wins.
module slot_entry
    import slot_pkg::*;
#(
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int PROFILE_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lock,
    input  logic                      set_src_addr,
    input  logic                      set_src_size,
    input  logic                      set_des_addr,
    input  logic                      set_des_size,
    input  logic                      set_status,
    input  logic [SRC_ADDR_WIDTH-1:0] inp_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0] inp_src_size,
    input  logic [DST_ADDR_WIDTH-1:0] inp_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0] inp_des_size,
    input  logic [1:0]                inp_status,
    input  logic                      seq_we_status,
    input  logic [1:0]                seq_status,
    input  logic                      seq_we_profile,
    input  logic [PROFILE_WIDTH-1:0]  seq_profile,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] src_size,
    output logic [DST_ADDR_WIDTH-1:0] des_addr,
    output logic [DST_SIZE_WIDTH-1:0] des_size,
    output logic [1:0]                status,
    output logic [PROFILE_WIDTH-1:0]  profile
);
    logic [SRC_ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [SRC_SIZE_WIDTH-1:0] src_size_q, src_size_d;
    logic [DST_ADDR_WIDTH-1:0] des_addr_q, des_addr_d;
    logic [DST_SIZE_WIDTH-1:0] des_size_q, des_size_d;
    logic [1:0]                status_q, status_d;
    logic [PROFILE_WIDTH-1:0]  profile_q, profile_d;

    always_comb begin
        src_addr_d = (set_src_addr && !lock) ? inp_src_addr : src_addr_q;
        src_size_d = (set_src_size && !lock) ? inp_src_size : src_size_q;
        des_addr_d = (set_des_addr && !lock) ? inp_des_addr : des_addr_q;
        des_size_d = (set_des_size && !lock) ? inp_des_size : des_size_q;
        status_d   = seq_we_status ? seq_status : (set_status && !lock) ? inp_status : status_q;
        profile_d  = seq_we_profile ? seq_profile : profile_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_addr_q <= '0;
            src_size_q <= '0;
            des_addr_q <= '0;
            des_size_q <= '0;
            status_q   <= ST_EMPTY;
            profile_q  <= '0;
        end else begin
            src_addr_q <= src_addr_d;
            src_size_q <= src_size_d;
            des_addr_q <= des_addr_d;
            des_size_q <= des_size_d;
            status_q   <= status_d;
            profile_q  <= profile_d;
        end
    end

    assign src_addr = src_addr_q;
    assign src_size = src_size_q;
    assign des_addr = des_addr_q;
    assign des_size = des_size_q;
    assign status   = status_q;
    assign profile  = profile_q;
endmodule

// File: rtl/slot_bank_sequencer.sv
// slot_bank_sequencer: bank of DMA descriptor slots plus a sequencer that issues
// each ARMED slot in order and writes back status and a cycle-count profile.
module slot_bank_sequencer
    import slot_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int IDX_WIDTH      = 2,
    parameter int SRC_ADDR_WIDTH = 32,
    parameter int SRC_SIZE_WIDTH = 26,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int DST_SIZE_WIDTH = 26,
    parameter int PROFILE_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [IDX_WIDTH-1:0]      wr_idx,
    input  logic [SRC_ADDR_WIDTH-1:0] inp_src_addr,
    input  logic [SRC_SIZE_WIDTH-1:0] inp_src_size,
    input  logic [DST_ADDR_WIDTH-1:0] inp_des_addr,
    input  logic [DST_SIZE_WIDTH-1:0] inp_des_size,
    input  logic [1:0]                inp_status,
    input  logic                      set_src_addr,
    input  logic                      set_src_size,
    input  logic                      set_des_addr,
    input  logic                      set_des_size,
    input  logic                      set_status,
    input  logic [IDX_WIDTH-1:0]      rd_idx,
    output logic [SRC_ADDR_WIDTH-1:0] rd_src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] rd_src_size,
    output logic [DST_ADDR_WIDTH-1:0] rd_des_addr,
    output logic [DST_SIZE_WIDTH-1:0] rd_des_size,
    output logic [1:0]                rd_status,
    output logic [PROFILE_WIDTH-1:0]  rd_profile,
    input  logic                      start,
    input  logic [IDX_WIDTH:0]        seq_len,
    output logic                      busy,
    output logic                      seq_done,
    output logic [IDX_WIDTH-1:0]      cur_idx,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [SRC_ADDR_WIDTH-1:0] cmd_src_addr,
    output logic [SRC_SIZE_WIDTH-1:0] cmd_src_size,
    output logic [DST_ADDR_WIDTH-1:0] cmd_des_addr,
    output logic [DST_SIZE_WIDTH-1:0] cmd_des_size,
    input  logic                      cmd_done
);
    localparam logic [PROFILE_WIDTH-1:0] PMAX = SAT[PROFILE_WIDTH-1:0];
    localparam logic [IDX_WIDTH:0]       NS   = (IDX_WIDTH+1)'(NUM_SLOTS);

    state_e                    state_q, state_d;
    logic [IDX_WIDTH-1:0]      cur_q, cur_d;
    logic [IDX_WIDTH:0]        len_q, len_d;
    logic [PROFILE_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                      done_q, done_d;
    logic                      seq_we_status, seq_we_profile, locked, last;
    logic [1:0]                seq_status;
    logic [IDX_WIDTH:0]        eff_len;

    logic [SRC_ADDR_WIDTH-1:0] src_addr_a [NUM_SLOTS];
    logic [SRC_SIZE_WIDTH-1:0] src_size_a [NUM_SLOTS];
    logic [DST_ADDR_WIDTH-1:0] des_addr_a [NUM_SLOTS];
    logic [DST_SIZE_WIDTH-1:0] des_size_a [NUM_SLOTS];
    logic [1:0]                status_a   [NUM_SLOTS];
    logic [PROFILE_WIDTH-1:0]  profile_a  [NUM_SLOTS];

    // The active slot is frozen while its command is pending or in flight.
    assign locked  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign eff_len = (seq_len > NS) ? NS : seq_len;
    assign last    = ({1'b0, cur_q} == len_q - 1'b1);
    assign cnt_inc = (cnt_q == PMAX) ? cnt_q : cnt_q + 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
            logic wsel, ssel;
            assign wsel = (wr_idx == IDX_WIDTH'(g));
            assign ssel = (cur_q == IDX_WIDTH'(g));
            slot_entry #(
                .SRC_ADDR_WIDTH(SRC_ADDR_WIDTH),
                .SRC_SIZE_WIDTH(SRC_SIZE_WIDTH),
                .DST_ADDR_WIDTH(DST_ADDR_WIDTH),
                .DST_SIZE_WIDTH(DST_SIZE_WIDTH),
                .PROFILE_WIDTH (PROFILE_WIDTH)
            ) u_entry (
                .clk           (clk),
                .reset         (reset),
                .lock          (locked && ssel),
                .set_src_addr  (set_src_addr && wsel),
                .set_src_size  (set_src_size && wsel),
                .set_des_addr  (set_des_addr && wsel),
                .set_des_size  (set_des_size && wsel),
                .set_status    (set_status && wsel),
                .inp_src_addr  (inp_src_addr),
                .inp_src_size  (inp_src_size),
                .inp_des_addr  (inp_des_addr),
                .inp_des_size  (inp_des_size),
                .inp_status    (inp_status),
                .seq_we_status (seq_we_status && ssel),
                .seq_status    (seq_status),
                .seq_we_profile(seq_we_profile && ssel),
                .seq_profile   (cnt_inc),
                .src_addr      (src_addr_a[g]),
                .src_size      (src_size_a[g]),
                .des_addr      (des_addr_a[g]),
                .des_size      (des_size_a[g]),
                .status        (status_a[g]),
                .profile       (profile_a[g])
            );
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        cmd_valid      = 1'b0;
        seq_we_status  = 1'b0;
        seq_we_profile = 1'b0;
        seq_status     = ST_BUSY;
        case (state_q)
            S_IDLE: if (start) begin
                len_d = eff_len;
                if (eff_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    cur_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: if (status_a[cur_q] != ST_ARMED) begin
                state_d = S_NEXT;
            end else begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    seq_we_status = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (cmd_done) begin
                    seq_we_status  = 1'b1;
                    seq_we_profile = 1'b1;
                    seq_status     = ST_DONE;
                    state_d        = S_NEXT;
                end
            end
            S_NEXT: if (last) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                cur_d   = cur_q + 1'b1;
                state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign seq_done     = done_q;
    assign cur_idx      = cur_q;
    assign rd_src_addr  = src_addr_a[rd_idx];
    assign rd_src_size  = src_size_a[rd_idx];
    assign rd_des_addr  = des_addr_a[rd_idx];
    assign rd_des_size  = des_size_a[rd_idx];
    assign rd_status    = status_a[rd_idx];
    assign rd_profile   = profile_a[rd_idx];
    assign cmd_src_addr = src_addr_a[cur_q];
    assign cmd_src_size = src_size_a[cur_q];
    assign cmd_des_addr = des_addr_a[cur_q];
    assign cmd_des_size = des_size_a[cur_q];
endmodule

// File: tb/tb_slot_bank_sequencer.sv
// tb_slot_bank_sequencer: directed stimulus with a command scoreboard checked
// by a negedge monitor; a small DMA responder returns cmd_done after a set delay.
module tb_slot_bank_sequencer;
    logic        clk = 0, reset = 1;
    logic [1:0]  wr_idx = 0, rd_idx = 0, inp_status = 0, rd_status, cur_idx;
    logic [31:0] inp_src_addr = 0, inp_des_addr = 0, rd_src_addr, rd_des_addr, cmd_src_addr, cmd_des_addr;
    logic [25:0] inp_src_size = 0, inp_des_size = 0, rd_src_size, rd_des_size, cmd_src_size, cmd_des_size;
    logic        set_src_addr = 0, set_src_size = 0, set_des_addr = 0, set_des_size = 0, set_status = 0;
    logic [3:0]  rd_profile;
    logic        start = 0, busy, seq_done, cmd_valid, cmd_ready = 1, cmd_done = 0;
    logic [2:0]  seq_len = 0;

    int          cmp = 0, bad = 0, done_cnt = 0, done_dly = 3;
    logic [31:0] exp_q[$];

    slot_bank_sequencer #(.PROFILE_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .wr_idx(wr_idx),
        .inp_src_addr(inp_src_addr), .inp_src_size(inp_src_size),
        .inp_des_addr(inp_des_addr), .inp_des_size(inp_des_size), .inp_status(inp_status),
        .set_src_addr(set_src_addr), .set_src_size(set_src_size),
        .set_des_addr(set_des_addr), .set_des_size(set_des_size), .set_status(set_status),
        .rd_idx(rd_idx), .rd_src_addr(rd_src_addr), .rd_src_size(rd_src_size),
        .rd_des_addr(rd_des_addr), .rd_des_size(rd_des_size), .rd_status(rd_status),
        .rd_profile(rd_profile), .start(start), .seq_len(seq_len), .busy(busy),
        .seq_done(seq_done), .cur_idx(cur_idx), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_src_size(cmd_src_size),
        .cmd_des_addr(cmd_des_addr), .cmd_des_size(cmd_des_size), .cmd_done(cmd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (seq_done) done_cnt++;
        if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                cmp++;
                bad++;
                $display("FAIL unexpected_cmd: got src %0h expected no command", cmd_src_addr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("cmd_src_addr", cmd_src_addr, e);
                chk("cmd_des_addr", cmd_des_addr, e + 32'h100);
                chk("cmd_src_size", cmd_src_size, e[25:0]);
                chk("cmd_des_size", cmd_des_size, e[25:0] + 26'd1);
            end
        end
    end

    // DMA responder: cmd_done is sampled done_dly edges after the accept edge.
    initial forever begin
        @(negedge clk);
        if (cmd_valid && cmd_ready && done_dly > 0) begin
            @(posedge clk);
            repeat (done_dly - 1) @(posedge clk);
            #1 cmd_done = 1;
            @(posedge clk);
            #1 cmd_done = 0;
        end
    end

    task automatic arm(input int i, input logic [31:0] a);
        wr_idx = 2'(i);
        inp_src_addr = a;
        inp_des_addr = a + 32'h100;
        inp_src_size = a[25:0];
        inp_des_size = a[25:0] + 26'd1;
        inp_status = 2'd1;
        {set_src_addr, set_src_size, set_des_addr, set_des_size, set_status} = 5'b11111;
        tick();
        {set_src_addr, set_src_size, set_des_addr, set_des_size, set_status} = 5'b00000;
    endtask

    task automatic wr_status(input int i, input logic [1:0] s);
        wr_idx = 2'(i);
        inp_status = s;
        set_status = 1;
        tick();
        set_status = 0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 300 && done_cnt == d0; k++) @(posedge clk);
        #1;
        repeat (3) tick();
        chk(name, 64'(done_cnt - d0), 1);
        chk({name, "_queue"}, 64'(exp_q.size()), 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    task automatic run(input string name, input logic [2:0] len);
        seq_len = len;
        start = 1;
        tick();
        start = 0;
        wait_done(name);
    endtask

    task automatic chk_slot(input int i, input logic [1:0] st, input logic [3:0] pr);
        rd_idx = 2'(i);
        #1;
        chk($sformatf("slot%0d_status", i), rd_status, st);
        chk($sformatf("slot%0d_profile", i), rd_profile, pr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        reset = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk("rst_src_addr", rd_src_addr, 0);
            chk("rst_src_size", rd_src_size, 0);
            chk("rst_des_addr", rd_des_addr, 0);
            chk("rst_des_size", rd_des_size, 0);
            chk("rst_status", rd_status, 0);
            chk("rst_profile", rd_profile, 0);
        end
        chk("rst_busy", busy, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_seq_done", seq_done, 0);

        // Full sequence: four commands in order, profile 3 each
        for (int i = 0; i < 4; i++) begin
            arm(i, 32'h1000 + 32'(i));
            exp_q.push_back(32'h1000 + 32'(i));
        end
        seq_len = 4;
        start = 1;
        tick();
        start = 0;
        chk("latency_cmd_valid", cmd_valid, 1);
        chk("latency_busy", busy, 1);
        wait_done("seq_all");
        for (int i = 0; i < 4; i++) chk_slot(i, 2'd3, 4'd3);

        // Slot 1 empty is skipped
        arm(0, 32'h2000);
        wr_status(1, 2'd0);
        arm(2, 32'h2002);
        arm(3, 32'h2003);
        exp_q.push_back(32'h2000);
        exp_q.push_back(32'h2002);
        exp_q.push_back(32'h2003);
        run("seq_skip", 3'd4);
        chk_slot(1, 2'd0, 4'd3);
        chk_slot(2, 2'd3, 4'd3);

        // Re-run without re-arming: no commands
        run("seq_rerun", 3'd4);

        // Stall in ISSUE with write-lock on the active slot
        arm(0, 32'h3000);
        cmd_ready = 0;
        seq_len = 4;
        start = 1;
        tick();
        start = 0;
        for (int c = 0; c < 5; c++) begin
            wr_idx = (c % 2 == 0) ? 2'd0 : 2'd3;
            inp_src_addr = (c % 2 == 0) ? 32'hDEAD : 32'hBEEF;
            set_src_addr = 1;
            start = (c == 2);
            tick();
            set_src_addr = 0;
            start = 0;
            chk("stall_valid", cmd_valid, 1);
            chk("stall_payload", cmd_src_addr, 32'h3000);
        end
        chk("stall_cur_idx", cur_idx, 0);
        rd_idx = 0;
        #1 chk("locked_slot", rd_src_addr, 32'h3000);
        rd_idx = 3;
        #1 chk("other_slot", rd_src_addr, 32'hBEEF);
        exp_q.push_back(32'h3000);
        cmd_ready = 1;
        wait_done("seq_stall");

        // seq_len 0: done pulse next cycle, no commands
        seq_len = 0;
        start = 1;
        tick();
        start = 0;
        chk("len0_done", seq_done, 1);
        chk("len0_busy", busy, 0);
        tick();
        chk("len0_done_fall", seq_done, 0);

        // seq_len 7 clamps to 4; cmd_done on first WAIT cycle gives profile 1
        done_dly = 1;
        for (int i = 0; i < 4; i++) begin
            arm(i, 32'h4000 + 32'(i));
            exp_q.push_back(32'h4000 + 32'(i));
        end
        run("seq_len7", 3'd7);
        chk("len7_cur_idx", cur_idx, 3);
        for (int i = 0; i < 4; i++) chk_slot(i, 2'd3, 4'd1);

        // Profile saturation with cmd_done withheld
        done_dly = 0;
        arm(0, 32'h5000);
        exp_q.push_back(32'h5000);
        seq_len = 1;
        start = 1;
        tick();
        start = 0;
        repeat (20) tick();
        chk("sat_busy", busy, 1);
        cmd_done = 1;
        tick();
        cmd_done = 0;
        wait_done("seq_sat");
        chk_slot(0, 2'd3, 4'd15);

        // Reset while in WAIT
        arm(0, 32'h6000);
        exp_q.push_back(32'h6000);
        seq_len = 1;
        start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        chk("wait_busy", busy, 1);
        reset = 1;
        #1;
        chk("wait_rst_busy", busy, 0);
        chk("wait_rst_valid", cmd_valid, 0);
        for (int i = 0; i < 4; i++) chk_slot(i, 2'd0, 4'd0);
        tick();
        reset = 0;
        tick();

        // Reset while a command is pending drops cmd_valid at once
        cmd_ready = 0;
        arm(0, 32'h7000);
        seq_len = 1;
        start = 1;
        tick();
        start = 0;
        chk("issue_valid", cmd_valid, 1);
        reset = 1;
        #1;
        chk("issue_rst_valid", cmd_valid, 0);
        chk("issue_rst_cur_idx", cur_idx, 0);
        tick();
        reset = 0;
        repeat (3) tick();
        chk("final_queue", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
